// File: rtl/wbuf_mac.sv
// Dot-product engine downstream of the weight buffer.
// Each accepted step adds (w_1*w_3 + w_2*w_4) into a saturating accumulator.
// After N_TERMS steps the 2-stage pipeline drains, done pulses for one cycle,
// and the result is held until the next start or reset.
//
// Ports:
//   clk         clock, all logic on rising edge
//   rst         synchronous active-high reset
//   start       begin a new run (honoured only in IDLE)
//   step_valid  w_1..w_4 carry a fresh operand set this cycle
//   w_1, w_2    SRAM operands (unsigned bytes)
//   w_3, w_4    SDRAM operands (unsigned bytes)
//   step_ready  high only while accumulating; steps are accepted only then
//   busy        high whenever not idle
//   done        one-cycle pulse, result final
//   overflow    sticky saturation flag for the current run
//   result      accumulator value, held after done
module wbuf_mac #(
    parameter int unsigned N_TERMS = 16,
    parameter int unsigned ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_valid,
    input  logic [7:0]       w_1,
    input  logic [7:0]       w_2,
    input  logic [7:0]       w_3,
    input  logic [7:0]       w_4,
    output logic             step_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [ACC_W-1:0] result
);

    localparam int unsigned      CNT_W   = $clog2(N_TERMS + 1);
    localparam int unsigned      SUM_W   = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(N_TERMS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StFin} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      pa_q, pb_q;
    logic             s1_valid_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic [16:0]      pp_sum;
    logic [SUM_W-1:0] sum;

    assign accept = (state_q == StAccum) && step_valid;
    assign pp_sum = {1'b0, pa_q} + {1'b0, pb_q};
    // One spare bit above the accumulator catches any overflow of a single add.
    assign sum    = {1'b0, acc_q} + SUM_W'(pp_sum);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        // Stage 2: fold in the product registered on the previous edge.
        if (s1_valid_q) begin
            if (sum[ACC_W]) begin
                acc_d = ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            StAccum: begin
                if (step_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_M1) begin
                        state_d = StDrain;
                    end
                end
            end
            // Stay until the final stage-1 product has landed in the accumulator.
            StDrain: begin
                if (!s1_valid_q) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pa_q       <= '0;
            pb_q       <= '0;
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            s1_valid_q <= accept;
            if (accept) begin
                pa_q <= 16'(w_1) * 16'(w_3);
                pb_q <= 16'(w_2) * 16'(w_4);
            end
        end
    end

    assign step_ready = (state_q == StAccum);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StFin);
    assign overflow   = ovf_q;
    assign result     = acc_q;

endmodule

// File: tb/tb_wbuf_mac.sv
// Self-checking bench for wbuf_mac: two instances (N_TERMS=4/ACC_W=24 and
// N_TERMS=16/ACC_W=20), a table of directed runs, reset/noise sequences and
// randomized runs compared against a plain arithmetic reference model.
module tb_wbuf_mac;

    localparam int unsigned NA   = 4;
    localparam int unsigned AW_A = 24;
    localparam int unsigned NB   = 16;
    localparam int unsigned AW_B = 20;

    logic clk;
    logic rst;
    logic start_a, start_b, valid_a, valid_b;
    logic [7:0] w_1, w_2, w_3, w_4;

    logic a_ready, a_busy, a_done, a_ovf;
    logic b_ready, b_busy, b_done, b_ovf;
    logic [AW_A-1:0] a_result;
    logic [AW_B-1:0] b_result;

    wbuf_mac #(.N_TERMS(NA), .ACC_W(AW_A)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .step_valid (valid_a),
        .w_1        (w_1),
        .w_2        (w_2),
        .w_3        (w_3),
        .w_4        (w_4),
        .step_ready (a_ready),
        .busy       (a_busy),
        .done       (a_done),
        .overflow   (a_ovf),
        .result     (a_result)
    );

    wbuf_mac #(.N_TERMS(NB), .ACC_W(AW_B)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .step_valid (valid_b),
        .w_1        (w_1),
        .w_2        (w_2),
        .w_3        (w_3),
        .w_4        (w_4),
        .step_ready (b_ready),
        .busy       (b_busy),
        .done       (b_done),
        .overflow   (b_ovf),
        .result     (b_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selected instance view.
    bit          sel;
    logic        o_ready, o_busy, o_done, o_ovf;
    logic [63:0] o_result;
    assign o_ready  = sel ? b_ready : a_ready;
    assign o_busy   = sel ? b_busy  : a_busy;
    assign o_done   = sel ? b_done  : a_done;
    assign o_ovf    = sel ? b_ovf   : a_ovf;
    assign o_result = sel ? 64'(b_result) : 64'(a_result);

    int errors = 0;
    int checks = 0;

    logic [7:0] vec_w [16][4];
    int         vec_gap [16];

    typedef struct {
        bit         sel;
        logic [7:0] w1, w2, w3, w4;
        int         gap_max;
        bit         noise;
        longint     exp_result;
        bit         exp_ovf;
    } rec_t;

    rec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic set_valid(input logic v);
        if (sel) valid_b = v;
        else     valid_a = v;
    endtask

    task automatic rand_w();
        w_1 = 8'($urandom);
        w_2 = 8'($urandom);
        w_3 = 8'($urandom);
        w_4 = 8'($urandom);
    endtask

    // Drive one full run from vec_w/vec_gap; the model is the saturating sum of
    // per-step dot products. noise=1 adds start pulses in ACCUM gaps and stray
    // step_valid in IDLE (alongside start), DRAIN and FIN.
    task automatic run(input bit noise, output longint fin_res, output bit fin_ovf);
        int     n;
        longint maxv;
        longint acc;
        bit     ovf;
        int     cnt;
        n    = sel ? NB : NA;
        maxv = sel ? ((longint'(1) << AW_B) - 1) : ((longint'(1) << AW_A) - 1);
        acc  = 0;
        ovf  = 1'b0;

        set_start(1'b1);
        set_valid(noise);
        rand_w();
        tick();
        set_start(1'b0);
        set_valid(1'b0);
        check("run_busy", o_busy, 1);
        check("run_ready", o_ready, 1);
        check("run_clear", o_result, 0);
        check("run_ovf_clear", o_ovf, 0);

        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < vec_gap[i]; g++) begin
                set_start(noise);
                rand_w();
                tick();
            end
            set_start(1'b0);
            w_1 = vec_w[i][0];
            w_2 = vec_w[i][1];
            w_3 = vec_w[i][2];
            w_4 = vec_w[i][3];
            set_valid(1'b1);
            tick();
            set_valid(1'b0);
            // Sum of all earlier steps is visible one edge after this accept.
            check("partial", o_result, acc);
            check("partial_ovf", o_ovf, ovf);
            acc = acc + longint'(vec_w[i][0]) * longint'(vec_w[i][2])
                      + longint'(vec_w[i][1]) * longint'(vec_w[i][3]);
            if (acc > maxv) begin
                acc = maxv;
                ovf = 1'b1;
            end
        end
        check("ready_drop", o_ready, 0);

        cnt = 0;
        while (!o_done && cnt < 8) begin
            set_valid(noise);
            rand_w();
            tick();
            cnt++;
        end
        set_valid(1'b0);
        check("done_latency", cnt, 2);
        check("done", o_done, 1);
        check("result", o_result, acc);
        check("overflow", o_ovf, ovf);
        tick();
        check("done_pulse", o_done, 0);
        check("busy_drop", o_busy, 0);
        check("result_held", o_result, acc);
        check("ovf_held", o_ovf, ovf);
        fin_res = acc;
        fin_ovf = ovf;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint r;
        bit     ov;

        tbl[0] = '{sel: 1'b0, w1: 8'd1,   w2: 8'd2,   w3: 8'd3,   w4: 8'd4,
                   gap_max: 0, noise: 1'b0, exp_result: 44,      exp_ovf: 1'b0};
        tbl[1] = '{sel: 1'b0, w1: 8'd1,   w2: 8'd1,   w3: 8'd1,   w4: 8'd1,
                   gap_max: 3, noise: 1'b0, exp_result: 8,       exp_ovf: 1'b0};
        tbl[2] = '{sel: 1'b0, w1: 8'd10,  w2: 8'd20,  w3: 8'd30,  w4: 8'd40,
                   gap_max: 1, noise: 1'b1, exp_result: 4400,    exp_ovf: 1'b0};
        tbl[3] = '{sel: 1'b1, w1: 8'd255, w2: 8'd255, w3: 8'd255, w4: 8'd255,
                   gap_max: 0, noise: 1'b0, exp_result: 'hFFFFF, exp_ovf: 1'b1};
        tbl[4] = '{sel: 1'b0, w1: 8'd255, w2: 8'd255, w3: 8'd255, w4: 8'd255,
                   gap_max: 2, noise: 1'b1, exp_result: 520200,  exp_ovf: 1'b0};
        tbl[5] = '{sel: 1'b1, w1: 8'd1,   w2: 8'd1,   w3: 8'd1,   w4: 8'd1,
                   gap_max: 1, noise: 1'b1, exp_result: 32,      exp_ovf: 1'b0};

        sel     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        w_1 = '0; w_2 = '0; w_3 = '0; w_4 = '0;

        // Reset from X state.
        rst = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #0;
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
            check("rst_ready", o_ready, 0);
            check("rst_ovf", o_ovf, 0);
            check("rst_result", o_result, 0);
        end
        rst = 1'b0;
        sel = 1'b0;

        // Directed table.
        for (int t = 0; t < 6; t++) begin
            sel = tbl[t].sel;
            for (int i = 0; i < 16; i++) begin
                vec_w[i][0] = tbl[t].w1;
                vec_w[i][1] = tbl[t].w2;
                vec_w[i][2] = tbl[t].w3;
                vec_w[i][3] = tbl[t].w4;
                vec_gap[i]  = i % (tbl[t].gap_max + 1);
            end
            run(tbl[t].noise, r, ov);
            check("tbl_result", r, tbl[t].exp_result);
            check("tbl_ovf", ov, tbl[t].exp_ovf);
        end

        // Reset on the second step of a run.
        sel = 1'b0;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        w_1 = 8'd9; w_2 = 8'd9; w_3 = 8'd9; w_4 = 8'd9;
        set_valid(1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_valid(1'b0);
        check("midrst_busy", o_busy, 0);
        check("midrst_ready", o_ready, 0);
        check("midrst_result", o_result, 0);
        check("midrst_ovf", o_ovf, 0);
        for (int i = 0; i < 16; i++) begin
            vec_w[i][0] = 8'd1; vec_w[i][1] = 8'd2; vec_w[i][2] = 8'd3; vec_w[i][3] = 8'd4;
            vec_gap[i]  = 0;
        end
        run(1'b0, r, ov);
        check("midrst_rerun", r, 44);

        // Randomized runs on both instances.
        for (int k = 0; k < 10; k++) begin
            sel = (k >= 7);
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 4; j++) begin
                    vec_w[i][j] = sel ? 8'($urandom_range(255, 120)) : 8'($urandom);
                end
                vec_gap[i] = int'($urandom_range(3, 0));
            end
            run(bit'($urandom_range(1, 0)), r, ov);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
